// File: rtl/lenet_layer_seq.sv
// rtl/lenet_layer_seq.sv - frame-level start/done sequencer for the LeNet layer controllers (optional watchdog: LAYER_TIMEOUT_EN)
module lenet_layer_seq #(
    parameter int N_LAYERS = 5,
    parameter int IDX_W    = 3,
    parameter int TO_W     = 16,
    parameter int TIMEOUT  = 40000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic [N_LAYERS-1:0] layer_done,
    input  logic                err_clr,
    output logic [N_LAYERS-1:0] layer_start,
    output logic [IDX_W-1:0]    layer_idx,
    output logic                busy,
    output logic                frame_done,
    output logic                drop_err,
    output logic                err_timeout,
    output logic [IDX_W-1:0]    err_layer
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
`ifdef LAYER_TIMEOUT_EN
        S_DONE,
        S_ERR
`else
        S_DONE
`endif
    } state_t;

    state_t              state;
    logic                pending;
    logic [N_LAYERS-1:0] idx_mask;
    logic                done_hit;
    logic                req_busy;

    // One-hot select of the current layer; used for both start and done matching.
    assign idx_mask = N_LAYERS'(1) << layer_idx;
    assign done_hit = |(layer_done & idx_mask);
    assign req_busy = frame_start && (state != S_IDLE);

`ifdef LAYER_TIMEOUT_EN
    logic [TO_W-1:0] wdog;
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr | (TIMEOUT == TO_W);
    assign err_timeout = 1'b0;
    assign err_layer   = '0;
`endif

    // Sequencer FSM, pending/drop bookkeeping and optional watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            pending   <= 1'b0;
            drop_err  <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
            wdog        <= '0;
            err_timeout <= 1'b0;
            err_layer   <= '0;
`endif
        end else begin
            // A request that arrives while busy is held once; a second one is lost.
            if (req_busy) begin
                if (pending) begin
                    drop_err <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    // pending can only be set here after an error was cleared.
                    if (frame_start || pending) begin
                        layer_idx <= '0;
                        pending   <= 1'b0;
                        state     <= S_START;
`ifdef LAYER_TIMEOUT_EN
                        err_timeout <= 1'b0;
                        err_layer   <= '0;
`endif
                    end
                end
                S_START: begin
                    // Done pulses in the start cycle are deliberately not looked at.
                    state <= S_WAIT;
`ifdef LAYER_TIMEOUT_EN
                    wdog <= '0;
`endif
                end
                S_WAIT: begin
                    if (done_hit) begin
                        if (layer_idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            layer_idx <= layer_idx + IDX_W'(1);
                            state     <= S_START;
                        end
`ifdef LAYER_TIMEOUT_EN
                    end else if (wdog == TO_W'(TIMEOUT - 1)) begin
                        state       <= S_ERR;
                        err_timeout <= 1'b1;
                        err_layer   <= layer_idx;
                        pending     <= 1'b0;
                    end else begin
                        wdog <= wdog + TO_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    // A request held or arriving now is served back-to-back.
                    if (pending || frame_start) begin
                        pending   <= 1'b0;
                        layer_idx <= '0;
                        state     <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
`ifdef LAYER_TIMEOUT_EN
                S_ERR: begin
                    if (err_clr) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state: no input-to-output combinational path.
    assign layer_start = (state == S_START) ? idx_mask : '0;
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_DONE);

endmodule

// File: tb/tb_lenet_layer_seq.sv
// tb/tb_lenet_layer_seq.sv - directed self-checking bench for lenet_layer_seq
module tb_lenet_layer_seq;

    localparam int DLY = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic [4:0] layer_done = '0;
    logic       err_clr = 1'b0;
    logic [4:0] layer_start;
    logic [2:0] layer_idx;
    logic       busy;
    logic       frame_done;
    logic       drop_err;
    logic       err_timeout;
    logic [2:0] err_layer;

    lenet_layer_seq #(
        .N_LAYERS(5),
        .IDX_W   (3),
        .TO_W    (16),
        .TIMEOUT (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .layer_done (layer_done),
        .err_clr    (err_clr),
        .layer_start(layer_start),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_err   (drop_err),
        .err_timeout(err_timeout),
        .err_layer  (err_layer)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit auto_en = 1'b0;
    int due = -1;
    int due_idx = 0;
    int st[5];
    int s0_q[$];
    int fd_q[$];
    int busy_first, busy_last, busy_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_trk();
        s0_q.delete();
        fd_q.delete();
        for (int i = 0; i < 5; i++) st[i] = -1;
        busy_first = -1;
        busy_last  = -1;
        busy_cnt   = 0;
        due        = -1;
    endtask

    // Advance one cycle; sample 1 time unit after the edge and play the layer model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) fd_q.push_back(cyc);
        if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            if (layer_start[i]) begin
                st[i] = cyc;
                if (i == 0) s0_q.push_back(cyc);
                if (auto_en) begin
                    due     = cyc + DLY;
                    due_idx = i;
                end
            end
        end
        if (auto_en) layer_done = (cyc == due) ? (5'd1 << due_idx) : 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_trk();
    endtask

    initial begin
        clear_trk();
        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_start", layer_start, 0);
        check("rst_idx", layer_idx, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_drop", drop_err, 0);
        check("rst_errto", err_timeout, 0);
        check("rst_errlayer", err_layer, 0);
        rst = 1'b0;

        // 1: single frame, frame_start in cycle 10
        auto_en = 1'b1;
        while (cyc < 10) tick();
        clear_trk();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (cyc < 125) tick();
        check("t1_start0", st[0], 11);
        check("t1_start1", st[1], 32);
        check("t1_start2", st[2], 53);
        check("t1_start3", st[3], 74);
        check("t1_start4", st[4], 95);
        check("t1_fd_cnt", fd_q.size(), 1);
        check("t1_fd_time", (fd_q.size() > 0) ? fd_q[0] : -1, 116);
        check("t1_busy_first", busy_first, 11);
        check("t1_busy_last", busy_last, 116);
        check("t1_busy_cnt", busy_cnt, 106);
        check("t1_errto", err_timeout, 0);

        // 2: back-to-back request while layer 2 runs
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (49) tick();
        check("t2_idx_at_req", layer_idx, 2);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 400 && fd_q.size() < 2; i++) tick();
        repeat (3) tick();
        check("t2_fd_cnt", fd_q.size(), 2);
        check("t2_s0_cnt", s0_q.size(), 2);
        check("t2_gap", (s0_q.size() > 1 && fd_q.size() > 0) ? s0_q[1] - fd_q[0] : -1, 1);
        check("t2_len2", (s0_q.size() > 1 && fd_q.size() > 1) ? fd_q[1] - s0_q[1] : -1, 105);
        check("t2_drop", drop_err, 0);
        check("t2_idle", busy, 0);

        // 3: three extra requests during one frame
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (9) tick();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        repeat (400) tick();
        check("t3_fd_cnt", fd_q.size(), 2);
        check("t3_drop", drop_err, 1);
        check("t3_idle", busy, 0);

        // 4: early and spurious done pulses
        do_reset();
        auto_en = 1'b0;
        layer_done = '0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t4_start0", layer_start, 5'b00001);
        layer_done = 5'b00001;
        tick();
        layer_done = '0;
        check("t4_early_idx", layer_idx, 0);
        check("t4_early_start", layer_start, 0);
        tick();
        check("t4_early_hold", layer_start, 0);
        layer_done = 5'b00001;
        tick();
        layer_done = '0;
        check("t4_start1", layer_start, 5'b00010);
        check("t4_idx1", layer_idx, 1);
        tick();
        layer_done = 5'b01000;
        tick();
        layer_done = '0;
        check("t4_spur_idx", layer_idx, 1);
        check("t4_spur_start", layer_start, 0);
        tick();
        check("t4_spur_hold", layer_start, 0);
        layer_done = 5'b00010;
        tick();
        layer_done = '0;
        check("t4_start2", layer_start, 5'b00100);
        check("t4_idx2", layer_idx, 2);

        // 5: reset while waiting on layer 2
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_idx", layer_idx, 0);
        check("t5_start", layer_start, 0);
        check("t5_fdone", frame_done, 0);
        tick();
        check("t5_stay_idle", busy, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_restart", layer_start, 5'b00001);
        check("t5_restart_idx", layer_idx, 0);

`ifdef LAYER_TIMEOUT_EN
        // 6: watchdog with TIMEOUT=100
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        layer_done = 5'b00001;
        tick();
        layer_done = '0;
        check("t6_start1", layer_start, 5'b00010);
        repeat (100) tick();
        check("t6_no_err_yet", err_timeout, 0);
        check("t6_busy_wait", busy, 1);
        tick();
        check("t6_errto", err_timeout, 1);
        check("t6_errlayer", err_layer, 1);
        check("t6_err_busy", busy, 1);
        check("t6_err_nostart", layer_start, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6_clr_idle", busy, 0);
        check("t6_clr_keep", err_timeout, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_new_clears", err_timeout, 0);
        check("t6_new_start", layer_start, 5'b00001);
        repeat (100) tick();
        layer_done = 5'b00001;
        tick();
        layer_done = '0;
        check("t6_edge_done_start", layer_start, 5'b00010);
        check("t6_edge_done_noerr", err_timeout, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
